mac_engine: RTL and testbench

Parametrised, pipelined multiply-accumulate engine for the matrix datapath: each beat multiplies TAPS matrix elements by TAPS vector elements, reduces the products through a registered adder tree, and accumulates across multiple beats so that rows longer than TAPS produce one dot product. It generalises the fixed 9-tap unsigned MAC with a runtime signed/unsigned mode, multi-beat accumulation and valid/ready handshakes on both sides. It sits between the operand fetch logic (A rows, X vector) and the result writeback port.

---
 rtl/mac_pkg.sv | 27 ++
 rtl/mac_adder_tree.sv | 40 ++++
 rtl/mac_engine.sv | 176 +++++++++++++++++
 tb/tb_mac_engine.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared defaults, result-width derivation and pipeline tag for the MAC engine.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package mac_pkg;

    localparam int TAPS_DEF      = 9;
    localparam int DW_DEF        = 8;
    localparam int MAX_BEATS_DEF = 16;

    // Result width that holds a full-length accumulation without wrapping.
    function automatic int calc_ow(input int taps, input int dw, input int max_beats);
        return 2 * dw + $clog2(taps) + $clog2(max_beats);
    endfunction

    // Number of operands left after `lvl` rounds of pairwise reduction of `n` operands.
    function automatic int level_count(input int n, input int lvl);
        return (n + (1 << lvl) - 1) >> lvl;
    endfunction

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic signed_mode;
    } tag_t;

endpackage

// File: rtl/mac_adder_tree.sv
// Pairwise reduction of N OW-bit operands to one sum; an odd operand passes through to the next level.
// Latency: combinational; the parent registers the output.
// Backpressure: none, pure logic.
module mac_adder_tree
    import mac_pkg::*;
#(
    parameter int N  = 9,
    parameter int OW = 24
) (
    input  logic [N*OW-1:0] operands,
    output logic [OW-1:0]   sum
);

    localparam int LEVELS = $clog2(N);

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int CIN  = level_count(N, l);
        localparam int COUT = level_count(N, l + 1);

        logic [CIN*OW-1:0]  vin;
        logic [COUT*OW-1:0] vout;

        if (l == 0) begin : g_src
            assign vin = operands;
        end else begin : g_src
            assign vin = g_lvl[l-1].vout;
        end

        for (genvar i = 0; i < COUT; i++) begin : g_node
            if (2 * i + 1 < CIN) begin : g_add
                assign vout[i*OW +: OW] = vin[2*i*OW +: OW] + vin[(2*i+1)*OW +: OW];
            end else begin : g_pass
                assign vout[i*OW +: OW] = vin[2*i*OW +: OW];
            end
        end
    end

    assign sum = g_lvl[LEVELS-1].vout;

endmodule

// File: rtl/mac_engine.sv
// Pipelined multi-beat multiply-accumulate: TAPS products per beat, registered adder tree, cross-beat accumulator.
// Latency: 3 cycles from accepted last beat to out_valid (multiply, reduce, accumulate stages).
// Backpressure: a held result (out_valid && !out_ready) freezes every stage and drops in_ready.
module mac_engine
    import mac_pkg::*;
#(
    parameter int  TAPS      = TAPS_DEF,
    parameter int  DW        = DW_DEF,
    parameter int  MAX_BEATS = MAX_BEATS_DEF,
    localparam int OW        = calc_ow(TAPS, DW, MAX_BEATS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [TAPS*DW-1:0] a_data,
    input  logic [TAPS*DW-1:0] x_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OW-1:0]      out_data,
    output logic               err
);

    localparam int PW = 2 * DW;
    localparam int CW = $clog2(MAX_BEATS) + 1;

    logic               en;
    logic               accept;
    logic               orphan;
    logic               overrun;
    logic               reopen;
    logic               open_acc;
    logic [CW-1:0]      beat_cnt;

    logic [TAPS*PW-1:0] prod;
    tag_t               s1_tag;
    logic [TAPS*PW-1:0] s1_prod;

    logic [TAPS*OW-1:0] ext;
    logic [OW-1:0]      tree_sum;
    logic               s2_valid;
    logic               s2_first;
    logic               s2_last;
    logic [OW-1:0]      s2_sum;

    logic [OW-1:0]      acc;
    logic [OW-1:0]      acc_next;

    // One enable for the whole pipeline: only a result that is held back stalls it.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    // Protocol classification of the beat being accepted this cycle.
    assign orphan  = accept && !in_first && !open_acc;
    assign overrun = accept && !in_first && open_acc && (beat_cnt >= CW'(MAX_BEATS));
    assign reopen  = accept && in_first && open_acc;

    // Track whether an accumulation is open and how many beats it has taken; flag protocol errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            open_acc <= 1'b0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            if (in_first) begin
                beat_cnt <= CW'(1);
                open_acc <= !in_last;
            end else if (open_acc) begin
                if (!overrun) begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
                if (in_last) begin
                    open_acc <= 1'b0;
                end
            end
            if (orphan || overrun || reopen) begin
                err <= 1'b1;
            end
        end
    end

    // Per-tap products; the beat's own mode picks sign or zero extension of the operands.
    always_comb begin
        prod = '0;
        for (int j = 0; j < TAPS; j++) begin
            if (signed_mode) begin
                prod[j*PW +: PW] = {{DW{a_data[j*DW + DW - 1]}}, a_data[j*DW +: DW]}
                                 * {{DW{x_data[j*DW + DW - 1]}}, x_data[j*DW +: DW]};
            end else begin
                prod[j*PW +: PW] = {{DW{1'b0}}, a_data[j*DW +: DW]}
                                 * {{DW{1'b0}}, x_data[j*DW +: DW]};
            end
        end
    end

    // S1: capture products and tags; an orphan beat is swallowed since there is nothing to add it to.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_tag <= '0;
        end else if (en) begin
            s1_tag.valid       <= accept && !orphan;
            s1_tag.first       <= in_first;
            s1_tag.last        <= in_last;
            s1_tag.signed_mode <= signed_mode;
        end
    end

    // S1 product data carries no control meaning, so it needs no reset.
    always_ff @(posedge clk) begin
        if (en) begin
            s1_prod <= prod;
        end
    end

    // Widen each product to the result width according to the mode it was computed in.
    always_comb begin
        ext = '0;
        for (int j = 0; j < TAPS; j++) begin
            if (s1_tag.signed_mode) begin
                ext[j*OW +: OW] = {{(OW-PW){s1_prod[j*PW + PW - 1]}}, s1_prod[j*PW +: PW]};
            end else begin
                ext[j*OW +: OW] = {{(OW-PW){1'b0}}, s1_prod[j*PW +: PW]};
            end
        end
    end

    mac_adder_tree #(
        .N  (TAPS),
        .OW (OW)
    ) u_tree (
        .operands (ext),
        .sum      (tree_sum)
    );

    // S2: register the reduced beat sum with its framing tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_sum   <= '0;
        end else if (en) begin
            s2_valid <= s1_tag.valid;
            s2_first <= s1_tag.first;
            s2_last  <= s1_tag.last;
            s2_sum   <= tree_sum;
        end
    end

    // A first beat restarts the running sum, discarding whatever was open.
    assign acc_next = s2_first ? s2_sum : acc + s2_sum;

    // S3: accumulate and present the result on the last beat; hold it until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (en && s2_valid) begin
                acc <= acc_next;
            end
            if (en && s2_valid && s2_last) begin
                out_valid <= 1'b1;
                out_data  <= acc_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mac_engine.sv
// Self-checking bench for mac_engine: dot-product model, per-cycle compare process, directed and random beats.
// Latency: checks the 3-cycle result latency explicitly on a single beat.
// Backpressure: randomised and held out_ready exercise stalls; data must stay stable while held.
`timescale 1ns/1ps
module tb_mac_engine;

    localparam int     TAPS  = 9;
    localparam int     DW    = 8;
    localparam int     MAXB  = 16;
    localparam int     OW    = 24;
    localparam longint OMASK = (64'd1 << OW) - 1;

    logic               clk         = 1'b0;
    logic               rst         = 1'b1;
    logic               signed_mode = 1'b0;
    logic               in_valid    = 1'b0;
    logic               in_first    = 1'b0;
    logic               in_last     = 1'b0;
    logic               out_ready   = 1'b1;
    logic [TAPS*DW-1:0] a_data      = '0;
    logic [TAPS*DW-1:0] x_data      = '0;
    logic               in_ready;
    logic               out_valid;
    logic               err;
    logic [OW-1:0]      out_data;

    always #5 clk = ~clk;

    mac_engine #(
        .TAPS      (TAPS),
        .DW        (DW),
        .MAX_BEATS (MAXB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .signed_mode (signed_mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_first    (in_first),
        .in_last     (in_last),
        .a_data      (a_data),
        .x_data      (x_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .err         (err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endfunction

    // ---------------- behavioural model ----------------
    longint exp_q[$];
    bit     m_open;
    int     m_cnt;
    longint m_acc;
    bit     m_err;

    function automatic longint dot(input logic [TAPS*DW-1:0] a, input logic [TAPS*DW-1:0] x, input bit sm);
        longint s;
        logic [DW-1:0] ae;
        logic [DW-1:0] xe;
        s = 0;
        for (int i = 0; i < TAPS; i++) begin
            ae = a[i*DW +: DW];
            xe = x[i*DW +: DW];
            if (sm) s += longint'($signed(ae)) * longint'($signed(xe));
            else    s += longint'(ae) * longint'(xe);
        end
        return s;
    endfunction

    // Model: observe accepted beats and predict results and the error flag.
    initial begin
        m_open = 0; m_cnt = 0; m_acc = 0; m_err = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                exp_q.delete();
                m_open = 0; m_cnt = 0; m_acc = 0; m_err = 0;
            end else if (in_valid && in_ready) begin
                if (in_first) begin
                    if (m_open) m_err = 1;
                    m_acc  = dot(a_data, x_data, signed_mode);
                    m_cnt  = 1;
                    m_open = !in_last;
                    if (in_last) exp_q.push_back(m_acc & OMASK);
                end else if (!m_open) begin
                    m_err = 1;
                end else begin
                    if (m_cnt + 1 > MAXB) m_err = 1;
                    else m_cnt++;
                    m_acc += dot(a_data, x_data, signed_mode);
                    if (in_last) begin
                        exp_q.push_back(m_acc & OMASK);
                        m_open = 0;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    bit            hold;
    logic [OW-1:0] hold_data;
    longint        e;
    initial begin
        hold = 0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                check(in_ready == (!out_valid || out_ready), "in_ready_rule",
                      longint'(in_ready), longint'(!out_valid || out_ready));
                check(err == m_err, "err_flag", longint'(err), longint'(m_err));
                if (hold)
                    check(out_valid && out_data == hold_data, "held_result_stable",
                          longint'(out_data), longint'(hold_data));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check(0, "unexpected_result", longint'(out_data), -1);
                    end else begin
                        e = exp_q.pop_front();
                        check(longint'(out_data) == e, "result", longint'(out_data), e);
                    end
                end
                hold      = out_valid && !out_ready;
                hold_data = out_data;
            end
        end
    end

    // Random backpressure when enabled.
    bit rand_ready = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [TAPS*DW-1:0] fill(input logic [DW-1:0] v);
        logic [TAPS*DW-1:0] r;
        for (int i = 0; i < TAPS; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [TAPS*DW-1:0] rnd_vec();
        logic [TAPS*DW-1:0] r;
        for (int i = 0; i < TAPS; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a beat and return #1 after the edge that accepts it; in_valid stays high.
    task automatic send(input bit f, input bit l, input bit sm,
                        input logic [TAPS*DW-1:0] a, input logic [TAPS*DW-1:0] x);
        bit ok;
        int guard;
        in_valid = 1; in_first = f; in_last = l; signed_mode = sm; a_data = a; x_data = x;
        ok = 0;
        guard = 0;
        while (!ok) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            guard++;
            if (!ok && guard > 200) begin
                check(0, "send_timeout", longint'(guard), 200);
                break;
            end
        end
    endtask

    task automatic do_reset();
        in_valid = 0;
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic expect_result(input longint exp, input string name);
        int g;
        g = 0;
        while (!out_valid && g < 50) begin
            tick();
            g++;
        end
        check(out_valid == 1'b1, {name, "_valid"}, longint'(out_valid), 1);
        check(longint'(out_data) == exp, name, longint'(out_data), exp);
    endtask

    logic [OW-1:0] got[$];
    int            gotc[$];
    bit            saw;
    int            g;

    initial begin
        // Reset state
        do_reset();
        check(out_valid == 1'b0, "reset_out_valid", longint'(out_valid), 0);
        check(out_data == '0, "reset_out_data", longint'(out_data), 0);
        check(err == 1'b0, "reset_err", longint'(err), 0);
        check(in_ready == 1'b1, "reset_in_ready", longint'(in_ready), 1);

        // Single unsigned beat, with latency pinned
        send(1, 1, 0, fill(8'hFF), fill(8'hFF));
        in_valid = 0;
        check(out_valid == 1'b0, "latency_k0", longint'(out_valid), 0);
        tick();
        check(out_valid == 1'b0, "latency_k1", longint'(out_valid), 0);
        tick();
        check(out_valid == 1'b1, "latency_k2", longint'(out_valid), 1);
        check(longint'(out_data) == 585225, "unsigned_single", longint'(out_data), 585225);
        tick();

        // Single signed beat: 9 * (-128 * 127) at 24 bits
        send(1, 1, 1, fill(8'h80), fill(8'h7F));
        in_valid = 0;
        expect_result(longint'(24'hFDC480), "signed_single");
        tick();

        // Full 16-beat accumulation
        send(1, 0, 0, fill(8'hFF), fill(8'hFF));
        for (int b = 0; b < 14; b++) send(0, 0, 0, fill(8'hFF), fill(8'hFF));
        send(0, 1, 0, fill(8'hFF), fill(8'hFF));
        in_valid = 0;
        expect_result(9363600, "sixteen_beats");
        check(err == 1'b0, "sixteen_no_err", longint'(err), 0);
        tick();

        // Seventeenth beat overruns the limit
        send(1, 0, 0, fill(8'h01), fill(8'h01));
        for (int b = 0; b < 16; b++) send(0, 0, 0, fill(8'h01), fill(8'h01));
        in_valid = 0;
        tick();
        check(err == 1'b1, "overrun_err", longint'(err), 1);
        do_reset();

        // Back-to-back single beats: one result per cycle, in order
        got.delete();
        gotc.delete();
        fork
            begin
                for (int k = 1; k <= 6; k++) send(1, 1, 0, fill(8'(k)), fill(8'(k + 1)));
                in_valid = 0;
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    if (out_valid) begin
                        got.push_back(out_data);
                        gotc.push_back(c);
                    end
                    tick();
                end
            end
        join
        check(got.size() == 6, "b2b_count", longint'(got.size()), 6);
        for (int k = 0; k < got.size() && k < 6; k++) begin
            check(longint'(got[k]) == longint'(9 * (k + 1) * (k + 2)), "b2b_value",
                  longint'(got[k]), longint'(9 * (k + 1) * (k + 2)));
            check(gotc[k] == gotc[0] + k, "b2b_spacing", longint'(gotc[k]), longint'(gotc[0] + k));
        end

        // Held result freezes the pipeline
        got.delete();
        out_ready = 0;
        fork
            begin
                send(1, 1, 0, fill(8'd2), fill(8'd3));
                send(1, 1, 0, fill(8'd4), fill(8'd5));
                send(1, 1, 0, fill(8'd6), fill(8'd7));
                in_valid = 0;
            end
            begin
                g = 0;
                while (!out_valid && g < 20) begin
                    tick();
                    g++;
                end
                for (int c = 0; c < 4; c++) begin
                    check(in_ready == 1'b0, "stall_in_ready", longint'(in_ready), 0);
                    check(out_data == 24'd54, "stall_data", longint'(out_data), 54);
                    tick();
                end
                out_ready = 1;
                for (int c = 0; c < 10; c++) begin
                    if (out_valid) got.push_back(out_data);
                    tick();
                end
            end
        join
        check(got.size() == 3, "stall_count", longint'(got.size()), 3);
        if (got.size() == 3) begin
            check(got[0] == 24'd54,  "stall_first",  longint'(got[0]), 54);
            check(got[1] == 24'd180, "stall_second", longint'(got[1]), 180);
            check(got[2] == 24'd378, "stall_third",  longint'(got[2]), 378);
        end

        // Orphan beat after reset: error, no result
        do_reset();
        send(0, 1, 0, fill(8'd3), fill(8'd3));
        in_valid = 0;
        saw = 0;
        for (int c = 0; c < 6; c++) begin
            saw |= out_valid;
            tick();
        end
        check(err == 1'b1, "orphan_err", longint'(err), 1);
        check(saw == 1'b0, "orphan_no_result", longint'(saw), 0);

        // First during an open accumulation: error, only the new result
        do_reset();
        send(1, 0, 0, fill(8'd1), fill(8'd1));
        send(1, 1, 0, fill(8'd2), fill(8'd3));
        in_valid = 0;
        expect_result(54, "reopen_result");
        check(err == 1'b1, "reopen_err", longint'(err), 1);
        tick();
        check(out_valid == 1'b0, "reopen_single_result", longint'(out_valid), 0);

        // Reset in the middle of an accumulation discards it
        do_reset();
        send(1, 0, 0, fill(8'd10), fill(8'd10));
        send(0, 0, 0, fill(8'd10), fill(8'd10));
        do_reset();
        check(out_valid == 1'b0, "midreset_out_valid", longint'(out_valid), 0);
        check(err == 1'b0, "midreset_err", longint'(err), 0);
        saw = 0;
        for (int c = 0; c < 4; c++) begin
            saw |= out_valid;
            tick();
        end
        check(saw == 1'b0, "midreset_quiet", longint'(saw), 0);
        send(1, 1, 0, fill(8'd10), fill(8'd10));
        in_valid = 0;
        expect_result(900, "midreset_fresh");
        tick();

        // Random legal traffic with random modes, bubbles and backpressure
        rand_ready = 1;
        for (int n = 0; n < 200; n++) begin
            int len;
            len = $urandom_range(1, MAXB);
            for (int b = 0; b < len; b++) begin
                send(b == 0, b == len - 1, 1'($urandom_range(0, 1)), rnd_vec(), rnd_vec());
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 0;
                    repeat ($urandom_range(1, 2)) tick();
                end
            end
        end
        in_valid = 0;
        rand_ready = 0;
        out_ready = 1;
        g = 0;
        while ((exp_q.size() != 0 || out_valid) && g < 100) begin
            tick();
            g++;
        end
        check(exp_q.size() == 0, "drain_empty", longint'(exp_q.size()), 0);
        check(err == 1'b0, "random_no_err", longint'(err), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
